// File: rtl/mips_cpu_control_if.sv
// Bus between the multicycle MIPS control FSM and its datapath.
// The slave modport is the controller side; the master modport is the datapath side.
interface mips_cpu_control_if;
  logic [31:0] instr_rdata;
  logic        mem_waitrequest;
  logic        zero;
  logic        equal;
  logic        negative;
  logic        jump_target_zero;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shift_amt;
  logic        alu_src_imm;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        pc_write;
  logic        branch_taken;
  logic [2:0]  state;
  logic        active;

  modport slave (
    input  instr_rdata, mem_waitrequest, zero, equal, negative, jump_target_zero,
    output alu_control, alu_shift_amt, alu_src_imm, ir_write, mem_read, mem_write,
           reg_write, pc_write, branch_taken, state, active
  );

  modport master (
    output instr_rdata, mem_waitrequest, zero, equal, negative, jump_target_zero,
    input  alu_control, alu_shift_amt, alu_src_imm, ir_write, mem_read, mem_write,
           reg_write, pc_write, branch_taken, state, active
  );
endinterface

// File: rtl/mips_cpu_control.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a HALT on JR $0.
// Strobes decode from the registered state and the current-cycle inputs so stalls and flags act immediately.
module mips_cpu_control (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_control_if.slave     bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADDU = 4'd0, ALU_SUBU = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR  = 4'd4, ALU_SRL  = 4'd5, ALU_SRA = 4'd6, ALU_SLL = 4'd7,
                         ALU_SLT  = 4'd8, ALU_SLTU = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06,
                         OP_BGTZ  = 6'h07, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08;

  state_t      state_q, state_d;
  logic [31:0] ir_q;

  logic [5:0] opcode, funct;
  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  // Register fields consumed by the datapath, not by the controller.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir_q[25:11];

  // Returns {supported, alu op} for an R-type funct field.
  function automatic logic [4:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'h21:   return {1'b1, ALU_ADDU};
      6'h23:   return {1'b1, ALU_SUBU};
      6'h24:   return {1'b1, ALU_AND};
      6'h25:   return {1'b1, ALU_OR};
      6'h26:   return {1'b1, ALU_XOR};
      6'h00:   return {1'b1, ALU_SLL};
      6'h02:   return {1'b1, ALU_SRL};
      6'h03:   return {1'b1, ALU_SRA};
      6'h2A:   return {1'b1, ALU_SLT};
      6'h2B:   return {1'b1, ALU_SLTU};
      default: return {1'b0, ALU_ADDU};
    endcase
  endfunction

  // Returns {supported, alu op} for an immediate ALU opcode.
  function automatic logic [4:0] itype_alu(input logic [5:0] op);
    case (op)
      6'h09:   return {1'b1, ALU_ADDU};
      6'h0C:   return {1'b1, ALU_AND};
      6'h0D:   return {1'b1, ALU_OR};
      6'h0E:   return {1'b1, ALU_XOR};
      6'h0A:   return {1'b1, ALU_SLT};
      6'h0B:   return {1'b1, ALU_SLTU};
      default: return {1'b0, ALU_ADDU};
    endcase
  endfunction

  logic [4:0] r_dec, i_dec;
  assign r_dec = rtype_alu(funct);
  assign i_dec = itype_alu(opcode);

  logic [3:0] alu_ctl;
  logic       alu_imm, irw, mrd, mwr, rwr, pcw, btk;

  always_comb begin
    state_d = state_q;
    alu_ctl = ALU_ADDU;
    alu_imm = 1'b0;
    irw     = 1'b0;
    mrd     = 1'b0;
    mwr     = 1'b0;
    rwr     = 1'b0;
    pcw     = 1'b0;
    btk     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mrd = 1'b1;
        if (!bus.mem_waitrequest) begin
          irw     = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_RTYPE) begin
          if (r_dec[4]) begin
            alu_ctl = r_dec[3:0];
            state_d = S_WB;
          end else if (funct == FN_JR) begin
            if (bus.jump_target_zero) begin
              state_d = S_HALT;
            end else begin
              pcw     = 1'b1;
              btk     = 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            pcw     = 1'b1;
            state_d = S_FETCH;
          end
        end else if (i_dec[4]) begin
          alu_ctl = i_dec[3:0];
          alu_imm = 1'b1;
          state_d = S_WB;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          alu_imm = 1'b1;
          state_d = S_MEM;
        end else if (opcode inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) begin
          alu_ctl = ALU_SUBU;
          pcw     = 1'b1;
          state_d = S_FETCH;
          case (opcode)
            OP_BEQ:  btk = bus.equal;
            OP_BNE:  btk = !bus.equal;
            OP_BLEZ: btk = bus.zero | bus.negative;
            default: btk = !bus.zero & !bus.negative;
          endcase
        end else begin
          pcw     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        alu_imm = 1'b1;
        if (opcode == OP_LW) mrd = 1'b1;
        else                 mwr = 1'b1;
        if (!bus.mem_waitrequest) begin
          if (opcode == OP_LW) begin
            state_d = S_WB;
          end else begin
            pcw     = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rwr     = 1'b1;
        pcw     = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Reset silences everything in the same cycle, including a stalled store.
    if (reset) begin
      alu_ctl = ALU_ADDU;
      alu_imm = 1'b0;
      irw     = 1'b0;
      mrd     = 1'b0;
      mwr     = 1'b0;
      rwr     = 1'b0;
      pcw     = 1'b0;
      btk     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if (irw) ir_q <= bus.instr_rdata;
    end
  end

  assign bus.alu_control   = alu_ctl;
  assign bus.alu_shift_amt = ir_q[10:6];
  assign bus.alu_src_imm   = alu_imm;
  assign bus.ir_write      = irw;
  assign bus.mem_read      = mrd;
  assign bus.mem_write     = mwr;
  assign bus.reg_write     = rwr;
  assign bus.pc_write      = pcw;
  assign bus.branch_taken  = btk;
  assign bus.state         = state_q;
  assign bus.active        = (state_q != S_HALT);

endmodule

// File: tb/tb_mips_cpu_control.sv
// Scoreboard bench for mips_cpu_control: a driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_cpu_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_control_if bus();

  mips_cpu_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Packed as {state, active, alu_control, alu_src_imm, shamt, irw, mrd, mwr, rwr, pcw, btk}
  typedef struct {
    logic [19:0] v;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ir_exp = 32'h0;

  // Strobe codes: {ir_write, mem_read, mem_write, reg_write, pc_write, branch_taken}
  localparam logic [5:0] NONE = 6'b000000, FET = 6'b110000, RD = 6'b010000, WR = 6'b001000,
                         WBK = 6'b000110, PCW = 6'b000010, TKN = 6'b000011;

  task automatic step(input logic rst, input logic [31:0] ins, input logic wt,
                      input logic z, input logic eq, input logic ng, input logic jtz,
                      input logic [2:0] st, input logic [3:0] ctl, input logic imm,
                      input logic [5:0] stb, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset                = rst;
    bus.instr_rdata      = ins;
    bus.mem_waitrequest  = wt;
    bus.zero             = z;
    bus.equal            = eq;
    bus.negative         = ng;
    bus.jump_target_zero = jtz;
    e.v    = {st, (st != 3'd5), ctl, imm, ir_exp[10:6], stb};
    e.name = nm;
    sb_q.push_back(e);
    if (rst)         ir_exp = 32'h0;
    else if (stb[5]) ir_exp = ins;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t        e;
      logic [19:0] got;
      e   = sb_q.pop_front();
      got = {bus.state, bus.active, bus.alu_control, bus.alu_src_imm, bus.alu_shift_amt,
             bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.pc_write,
             bus.branch_taken};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got st=%0d act=%0b alu=%0d imm=%0b sh=%0d stb=%06b, want st=%0d act=%0b alu=%0d imm=%0b sh=%0d stb=%06b",
                 e.name, got[19:17], got[16], got[15:12], got[11], got[10:6], got[5:0],
                 e.v[19:17], e.v[16], e.v[15:12], e.v[11], e.v[10:6], e.v[5:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.instr_rdata = '0; bus.mem_waitrequest = 1'b0; bus.zero = 1'b0; bus.equal = 1'b0;
    bus.negative = 1'b0; bus.jump_target_zero = 1'b0;
    repeat (2) @(posedge clk);

    step(1, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, NONE, "reset_state");
    // ADDU $3,$1,$2 with one fetch stall first
    step(0, 32'h0000_0000, 1, 0, 0, 0, 0, 3'd0, 4'd0, 0, RD,   "fetch_stall");
    step(0, 32'h0022_1821, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "addu_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "addu_decode");
    step(0, 0,             0, 0, 0, 0, 0, 3'd2, 4'd0, 0, NONE, "addu_exec");
    step(0, 0,             0, 0, 0, 0, 0, 3'd4, 4'd0, 0, WBK,  "addu_wb");
    // ORI: I-type with immediate
    step(0, 32'h3422_0005, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "ori_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "ori_decode");
    step(0, 0,             0, 0, 0, 0, 0, 3'd2, 4'd3, 1, NONE, "ori_exec");
    step(0, 0,             0, 0, 0, 0, 0, 3'd4, 4'd0, 0, WBK,  "ori_wb");
    // SRA $3,$2,2: shift amount comes from IR[10:6]
    step(0, 32'h0002_1883, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "sra_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "sra_decode");
    step(0, 0,             0, 0, 0, 0, 0, 3'd2, 4'd6, 0, NONE, "sra_exec");
    step(0, 0,             0, 0, 0, 0, 0, 3'd4, 4'd0, 0, WBK,  "sra_wb");
    // LW with three stalled MEM cycles
    step(0, 32'h8C22_0004, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "lw_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "lw_decode");
    step(0, 0,             1, 0, 0, 0, 0, 3'd2, 4'd0, 1, NONE, "lw_exec");
    step(0, 0,             1, 0, 0, 0, 0, 3'd3, 4'd0, 1, RD,   "lw_mem_stall1");
    step(0, 0,             1, 0, 0, 0, 0, 3'd3, 4'd0, 1, RD,   "lw_mem_stall2");
    step(0, 0,             1, 0, 0, 0, 0, 3'd3, 4'd0, 1, RD,   "lw_mem_stall3");
    step(0, 0,             0, 0, 0, 0, 0, 3'd3, 4'd0, 1, RD,   "lw_mem_release");
    step(0, 0,             0, 0, 0, 0, 0, 3'd4, 4'd0, 0, WBK,  "lw_wb");
    // BEQ taken, then not taken
    step(0, 32'h1022_0003, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "beq1_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "beq1_decode");
    step(0, 0,             0, 0, 1, 0, 0, 3'd2, 4'd1, 0, TKN,  "beq_taken");
    step(0, 32'h1022_0003, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "beq2_fetch");
    step(0, 0,             0, 0, 1, 0, 0, 3'd1, 4'd0, 0, NONE, "beq2_decode");
    step(0, 0,             0, 0, 0, 0, 0, 3'd2, 4'd1, 0, PCW,  "beq_not_taken");
    // BGTZ with a negative operand, BLEZ with a zero operand
    step(0, 32'h1C20_0003, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "bgtz_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "bgtz_decode");
    step(0, 0,             0, 0, 0, 1, 0, 3'd2, 4'd1, 0, PCW,  "bgtz_neg_not_taken");
    step(0, 32'h1820_0003, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "blez_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "blez_decode");
    step(0, 0,             0, 1, 0, 0, 0, 3'd2, 4'd1, 0, TKN,  "blez_zero_taken");
    // Unsupported opcode behaves as a NOP
    step(0, 32'hFC00_0000, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "nop_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "nop_decode");
    step(0, 0,             0, 0, 0, 0, 0, 3'd2, 4'd0, 0, PCW,  "nop_exec");
    // JR $1 to a nonzero target
    step(0, 32'h0020_0008, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "jr1_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "jr1_decode");
    step(0, 0,             0, 0, 0, 0, 0, 3'd2, 4'd0, 0, TKN,  "jr_nonzero");
    // SW interrupted by reset while stalled in MEM
    step(0, 32'hAC22_0004, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "sw_fetch");
    step(0, 0,             0, 0, 0, 0, 0, 3'd1, 4'd0, 0, NONE, "sw_decode");
    step(0, 0,             1, 0, 0, 0, 0, 3'd2, 4'd0, 1, NONE, "sw_exec");
    step(0, 0,             1, 0, 0, 0, 0, 3'd3, 4'd0, 1, WR,   "sw_mem_stall");
    step(1, 0,             1, 0, 0, 0, 0, 3'd3, 4'd0, 0, NONE, "sw_reset_kills_write");
    step(0, 0,             1, 0, 0, 0, 0, 3'd0, 4'd0, 0, RD,   "post_reset_fetch_stall");
    // JR $0 halts; HALT holds until reset
    step(0, 32'h0000_0008, 0, 0, 0, 0, 1, 3'd0, 4'd0, 0, FET,  "jr0_fetch");
    step(0, 0,             0, 0, 0, 0, 1, 3'd1, 4'd0, 0, NONE, "jr0_decode");
    step(0, 0,             0, 0, 0, 0, 1, 3'd2, 4'd0, 0, NONE, "jr0_exec_no_pcw");
    step(0, 0,             0, 0, 0, 0, 0, 3'd5, 4'd0, 0, NONE, "halt1");
    step(0, 32'h0022_1821, 0, 0, 1, 0, 0, 3'd5, 4'd0, 0, NONE, "halt_absorbing");
    step(1, 0,             0, 0, 0, 0, 0, 3'd5, 4'd0, 0, NONE, "halt_reset");
    step(0, 0,             1, 0, 0, 0, 0, 3'd0, 4'd0, 0, RD,   "after_halt_fetch");
    step(0, 32'h0022_1821, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, FET,  "after_halt_load");

    begin
      int budget = 10;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d entries left, want 0", sb_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_control.md
MIPS_CPU_CONTROL -- requirements
Module: mips_cpu_control

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 instr_rdata  in  32  instruction word from memory, valid when mem_waitrequest=0 in FETCH.
REQ-004 mem_waitrequest  in  1  memory stall; 1 holds current memory access.
REQ-005 zero, equal, negative  in  1 each  ALU flags (alu_a==0, alu_a==alu_b, alu_a<0 signed).
REQ-006 jump_target_zero  in  1  register operand of JR equals 0x00000000.
REQ-007 alu_control  out  4  ALU opcode: ADDU=0, SUBU=1, AND=2, OR=3, XOR=4, SRL=5, SRA=6, SLL=7, SLT=8, SLTU=9.
REQ-008 alu_shift_amt  out  5  IR[10:6].
REQ-009 alu_src_imm  out  1  1 selects extended immediate as alu_b.
REQ-010 ir_write, mem_read, mem_write, reg_write, pc_write, branch_taken  out  1 each  datapath strobes.
REQ-011 state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-012 active  out  1  0 only in HALT.

Function
REQ-013 Internal 32-bit IR SHALL load instr_rdata on the cycle ir_write=1.
REQ-014 FETCH: mem_read=1; mem_waitrequest=1 -> stay; mem_waitrequest=0 -> ir_write=1, next DECODE.
REQ-015 DECODE: one cycle, no strobes, next EXEC.
REQ-016 EXEC: alu_control/alu_src_imm from IR; R-type ALU and I-type ALU -> WB; LW/SW -> MEM (alu_control=ADDU, alu_src_imm=1).
REQ-017 R-type funct map: 0x21 ADDU, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x2A SLT, 0x2B SLTU.
REQ-018 I-type opcode map: 0x09 ADDU, 0x0C AND, 0x0D OR, 0x0E XOR, 0x0A SLT, 0x0B SLTU; all with alu_src_imm=1.
REQ-019 Branches in EXEC (alu_control=SUBU, alu_src_imm=0): BEQ(0x04) taken if equal; BNE(0x05) if !equal; BLEZ(0x06) if zero|negative; BGTZ(0x07) if !zero&!negative; pc_write=1, branch_taken=taken, next FETCH; flags sampled that cycle only; no delay slot.
REQ-020 JR (R-type funct 0x08) in EXEC: jump_target_zero=1 -> HALT, no pc_write; else pc_write=1, branch_taken=1, next FETCH.
REQ-021 MEM: LW mem_read=1, SW mem_write=1, held while mem_waitrequest=1; on release LW -> WB, SW -> pc_write=1, next FETCH.
REQ-022 WB: reg_write=1, pc_write=1 for exactly one cycle, next FETCH.
REQ-023 Unsupported opcode/funct: treated as NOP; EXEC asserts pc_write=1, next FETCH; no reg_write/mem strobes.
REQ-024 alu_control SHALL be ADDU and alu_src_imm=0 in every state other than EXEC/MEM.
REQ-025 Every strobe SHALL be 0 in any state not listed for it above; pc_write at most once per instruction.
REQ-026 HALT: absorbing; all strobes 0, active=0, until reset.

Reset
REQ-027 reset=1 SHALL force state=FETCH, IR=0x00000000 next edge, and all strobes 0 while reset is high, overriding any in-progress state including MEM stall or HALT.
REQ-028 First cycle after reset deasserts: state=FETCH, active=1, mem_read=1.

Verification
REQ-029 ADDU $3,$1,$2 (0x00221821), no stall -> states 0,1,2,4,0; alu_control=0 in EXEC; reg_write+pc_write in WB; 5 cycles.
REQ-030 LW (0x8C220004) with mem_waitrequest=1 for 3 MEM cycles -> mem_read held 4 MEM cycles, then WB with reg_write=1.
REQ-031 BEQ (0x10220003) with equal=1 -> EXEC pc_write=1, branch_taken=1; equal=0 -> pc_write=1, branch_taken=0.
REQ-032 BGTZ with zero=0, negative=1 -> branch_taken=0; BLEZ with zero=1 -> branch_taken=1.
REQ-033 JR $0 (0x00000008), jump_target_zero=1 -> HALT, active=0, no pc_write; reset held 1 cycle -> FETCH, mem_read=1.
REQ-034 Reset asserted mid-SW in MEM with mem_waitrequest=1 -> mem_write=0 immediately, FETCH after release.
